// File: rtl/i2c_slave_if.sv
// Host-side interface of the I2C target: byte hand-off between the bus
// engine and the local logic.
//
// Handshake: tx_req is a one-cycle request; the host answers by placing the
// next byte on data_tx and holding it stable until the following scl falling
// edge, when the target loads it. rx_valid is a one-cycle strobe with no
// back-pressure: data_rx is valid from that cycle until the next strobe.
interface i2c_slave_if;
  logic [7:0] data_tx;
  logic       tx_req;
  logic [7:0] data_rx;
  logic       rx_valid;
  logic       rw;
  logic       busy;

  modport slave (
    input  data_tx,
    output tx_req,
    output data_rx,
    output rx_valid,
    output rw,
    output busy
  );

  modport master (
    output data_tx,
    input  tx_req,
    input  data_rx,
    input  rx_valid,
    input  rw,
    input  busy
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address, oversampling scl/sda on the system clock.
// Receives write bytes, returns host-supplied bytes on reads, no stretching.
module i2c_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  i2c_slave_if.slave  host,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_t;

  // Synchronizer stages plus one history flop for edge detection.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic [7:0] data_rx_q, data_rx_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  // Two-flop synchronizers on both bus lines; idle bus level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // START/STOP need scl high in both the current and previous sample so an
  // sda change that coincides with an scl edge is never taken as a condition.
  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

  // State and datapath registers; sda_oe resets asynchronously so the line
  // is released the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      data_rx_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      data_rx_q   <= data_rx_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
    end
  end

  // Next-state logic. Bus conditions override any bit-level activity; bits
  // are sampled on scl rise and sda is only changed on scl fall.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    data_rx_d   = data_rx_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;

    if (stop_det) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (shift_q[7:1] == SLV_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              // Not us: stay off the bus until the next condition.
              state_d  = WAIT_STOP;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_rise) begin
            if (rw_q) tx_req_d = 1'b1;
          end else if (scl_fall) begin
            if (rw_q) begin
              // ACK slot ends and the first read bit goes out on the same edge.
              state_d  = TX;
              shift_d  = host.data_tx;
              sda_oe_d = ~host.data_tx[7];
            end else begin
              state_d  = RX;
              sda_oe_d = 1'b0;
            end
          end
        end

        RX: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_rx_d   = {shift_q[6:0], sda_s2};
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            state_d     = RX_ACK;
            sda_oe_d    = 1'b1;
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            state_d  = RX;
            sda_oe_d = 1'b0;
          end
        end

        TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              state_d     = TX_ACK;
              sda_oe_d    = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              tx_req_d = 1'b1;
            end else begin
              state_d  = WAIT_STOP;
              busy_d   = 1'b0;
              sda_oe_d = 1'b0;
            end
          end else if (scl_fall) begin
            // Only reached after an ACK; a NACK has already left this state.
            state_d  = TX;
            shift_d  = host.data_tx;
            sda_oe_d = ~host.data_tx[7];
          end
        end

        IDLE, WAIT_STOP: begin
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Open-drain output: only ever pulls low.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign host.tx_req   = tx_req_q;
  assign host.data_rx  = data_rx_q;
  assign host.rx_valid = rx_valid_q;
  assign host.rw       = rw_q;
  assign host.busy     = busy_q;
  assign dbg_state     = state_q;

endmodule
